fx_fir_tdm: RTL and testbench

Parametrised, time-multiplexed fixed-point FIR filter: a single multiply-accumulate unit walks a loadable coefficient bank against a sample delay line, one tap per clock. It uses the codebase's sign-magnitude Q0.(DATA_W-1) sample and coefficient format. It replaces the fully parallel 30-multiplier filter in the filter-bank channels, adding:
- run-time coefficient loading
- valid/ready flow control
- a wide accumulator with output saturation

---
 rtl/fx_fir_pkg.sv | 48 ++++
 rtl/fx_sm_mac.sv | 56 +++++
 rtl/fx_fir_tdm.sv | 163 ++++++++++++++++
 tb/tb_fx_fir_tdm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_fir_pkg.sv
// Shared types and sign-magnitude helpers for the time-multiplexed FIR.
package fx_fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDone
    } fir_state_e;

    // Sign-magnitude (data_w bits, sign at data_w-1) to two's complement.
    // -0 folds to 0 because the negated magnitude is zero.
    function automatic logic signed [31:0] sm2tc(input logic [31:0] sm,
                                                 input int unsigned data_w);
        logic [31:0] mag;
        mag = sm & ((32'd1 << (data_w - 1)) - 32'd1);
        if (sm[data_w - 1]) begin
            return -$signed(mag);
        end
        return $signed(mag);
    endfunction

    // Accumulator to sign-magnitude output: {sat, value}. Magnitude is
    // |acc| >> (data_w-1), clamped to full scale; a zero result is always +0.
    function automatic logic [32:0] tc2sm_sat(input logic signed [63:0] acc,
                                              input int unsigned data_w);
        logic [63:0] mag;
        logic [63:0] max_mag;
        logic        neg;
        logic        sat;
        neg     = acc[63];
        mag     = neg ? -acc : acc;
        mag     = mag >> (data_w - 1);
        max_mag = (64'd1 << (data_w - 1)) - 64'd1;
        sat     = (mag > max_mag);
        if (sat) begin
            mag = max_mag;
        end
        neg = neg && (mag != 64'd0);
        return {sat, 32'(mag) | (neg ? (32'd1 << (data_w - 1)) : 32'd0)};
    endfunction

    // Product bits plus enough guard bits to sum every tap without overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned taps);
        return 2 * data_w - 1 + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/fx_sm_mac.sv
// Sign-magnitude multiply-accumulate: converts both operands to two's
// complement, registers the product, then adds it into the accumulator.
module fx_sm_mac
    import fx_fir_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ACC_W  = acc_width(10, 30)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [DATA_W-1:0]        coef_i,
    input  logic [DATA_W-1:0]        sample_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int unsigned ProdW = 2 * DATA_W - 1;

    logic signed [DATA_W-1:0] coef_tc;
    logic signed [DATA_W-1:0] sample_tc;
    logic signed [ProdW-1:0]  prod_d;
    logic signed [ProdW-1:0]  prod_q;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q;

    // Operand conversion and signed product.
    always_comb begin
        coef_tc   = DATA_W'(sm2tc(32'(coef_i), DATA_W));
        sample_tc = DATA_W'(sm2tc(32'(sample_i), DATA_W));
        prod_d    = ProdW'(coef_tc) * ProdW'(sample_tc);
    end

    // Product register feeds the accumulator one cycle later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else if (clr_i) begin
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= en_i;
            if (en_i) begin
                prod_q <= prod_d;
            end
            if (prod_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fx_fir_tdm.sv
// Time-multiplexed sign-magnitude FIR: one MAC walks all taps per sample,
// with run-time coefficient loading and a saturating output stage.
module fx_fir_tdm
    import fx_fir_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned TAPS   = 30,
    parameter int unsigned AW     = $clog2(TAPS)
) (
    input  logic              clk_slow,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] fir_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] fir_out,
    output logic              sat,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_err
);

    localparam int unsigned AccW = acc_width(DATA_W, TAPS);
    // One extra bit so idx can reach TAPS for the accumulator drain cycle.
    localparam int unsigned IdxW = AW + 1;

    fir_state_e        state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              accept;
    logic              issue;
    logic              mac_clr;
    logic              coef_wr;
    logic              addr_ok;
    logic [DATA_W-1:0] coef_q [TAPS];
    logic [DATA_W-1:0] dl_q   [TAPS];
    logic [DATA_W-1:0] coef_sel;
    logic [DATA_W-1:0] dl_sel;
    logic signed [AccW-1:0] acc;
    logic [32:0]       conv;
    logic              unused_conv;
    logic [DATA_W-1:0] fir_out_q;
    logic              out_valid_q;
    logic              sat_q;
    logic              coef_err_q;

    assign in_ready = rst && (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign addr_ok  = ({1'b0, coef_addr} < IdxW'(TAPS));
    assign coef_wr  = coef_we && (state_q == StIdle) && addr_ok;

    // Next-state logic: IDLE waits for a sample, MAC issues TAPS products
    // plus one drain cycle for the product register, DONE converts.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mac_clr = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMac;
                    idx_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            StMac: begin
                if (idx_q < IdxW'(TAPS)) begin
                    issue = 1'b1;
                    idx_d = idx_q + IdxW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state and tap index registers.
    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Delay line shifts on sample accept; coefficients load only in IDLE.
    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
                dl_q[k]   <= '0;
            end
        end else begin
            if (accept) begin
                dl_q[0] <= fir_in;
                for (int k = 1; k < TAPS; k++) begin
                    dl_q[k] <= dl_q[k-1];
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                if (coef_wr && ({1'b0, coef_addr} == IdxW'(k))) begin
                    coef_q[k] <= coef_data;
                end
            end
        end
    end

    // Tap select; the drain index (TAPS) matches nothing and reads zero.
    always_comb begin
        coef_sel = '0;
        dl_sel   = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (idx_q == IdxW'(k)) begin
                coef_sel = coef_q[k];
                dl_sel   = dl_q[k];
            end
        end
    end

    fx_sm_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (AccW)
    ) u_mac (
        .clk_i    (clk_slow),
        .rst_ni   (rst),
        .clr_i    (mac_clr),
        .en_i     (issue),
        .coef_i   (coef_sel),
        .sample_i (dl_sel),
        .acc_o    (acc)
    );

    assign conv        = tc2sm_sat(64'(acc), DATA_W);
    assign unused_conv = ^conv[31:DATA_W];

    // Output register, sticky saturation flag and write-reject pulse.
    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            fir_out_q   <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            out_valid_q <= (state_q == StDone);
            coef_err_q  <= coef_we && !coef_wr;
            if (state_q == StDone) begin
                fir_out_q <= conv[DATA_W-1:0];
                sat_q     <= sat_q | conv[32];
            end
        end
    end

    assign fir_out   = fir_out_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fx_fir_tdm.sv
// Directed bench for fx_fir_tdm with hand-computed expected outputs.
module tb_fx_fir_tdm;

    localparam int unsigned TAPS = 30;
    localparam int unsigned LAT  = TAPS + 2;

    logic       clk_slow = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] fir_in   = '0;
    logic       out_valid;
    logic [9:0] fir_out;
    logic       sat;
    logic       coef_we  = 1'b0;
    logic [4:0] coef_addr = '0;
    logic [9:0] coef_data = '0;
    logic       coef_err;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    always #5 clk_slow = ~clk_slow;

    fx_fir_tdm #(
        .DATA_W (10),
        .TAPS   (TAPS),
        .AW     (5)
    ) dut (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fir_in    (fir_in),
        .out_valid (out_valid),
        .fir_out   (fir_out),
        .sat       (sat),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_slow);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic write_coef(input int addr, input logic [9:0] data);
        coef_we   = 1'b1;
        coef_addr = 5'(addr);
        coef_data = data;
        tick();
        coef_we = 1'b0;
    endtask

    // Waits for in_ready, then offers one sample (optionally with a
    // coefficient write on the same edge).
    task automatic send(input logic [9:0] x, input logic we = 1'b0,
                        input int addr = 0, input logic [9:0] data = '0);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        fir_in    = x;
        coef_we   = we;
        coef_addr = 5'(addr);
        coef_data = data;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        fir_in   = '0;
        coef_we  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [9:0] exp);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(cyc - acc_cyc), LAT);
        chk({tag, " value"}, {22'd0, fir_out}, {22'd0, exp});
        chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int np;
        int pulses;
        int s;

        // Reset state.
        tick();
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst fir_out", {22'd0, fir_out}, 32'd0);
        chk("rst sat", {31'd0, sat}, 32'd0);
        chk("rst coef_err", {31'd0, coef_err}, 32'd0);
        rst = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);

        // Impulse: coef[k]=k+1, 0x1FF then zeros -> output n is floor((n+1)*511/512) = n.
        for (int k = 0; k < TAPS; k++) write_coef(k, 10'(k + 1));
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 10'h1FF : 10'h000);
            if (n == 0) chk("busy in_ready", {31'd0, in_ready}, 32'd0);
            wait_out($sformatf("impulse %0d", n), 10'(n));
        end

        // Negative zero and negative results.
        do_reset();
        write_coef(0, 10'h200);
        send(10'h155);
        wait_out("negzero coef", 10'h000);
        write_coef(0, 10'h201);          // -1 * 341 -> |acc|>>9 = 0 -> +0
        send(10'h155);
        wait_out("negzero trunc", 10'h000);
        write_coef(0, 10'h3FF);          // -511 * 256 >> 9 = 255, negative
        send(10'h100);
        wait_out("negative", 10'h2FF);

        // Saturation: each full-scale tap contributes 261121.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 10'h1FF);
        send(10'h1FF);
        wait_out("sat ramp0", 10'h1FE);
        chk("sat before clamp", {31'd0, sat}, 32'd0);
        send(10'h1FF);
        wait_out("sat ramp1", 10'h1FF);
        chk("sat set", {31'd0, sat}, 32'd1);
        send(10'h1FF);
        wait_out("sat ramp2", 10'h1FF);
        send(10'h3FF);                   // net +2 taps
        wait_out("sat neg1", 10'h1FF);
        send(10'h3FF);                   // net +1
        wait_out("sat neg2", 10'h1FE);
        send(10'h3FF);                   // net 0
        wait_out("sat neg3", 10'h000);
        send(10'h3FF);                   // net -1
        wait_out("sat neg4", 10'h3FE);
        send(10'h3FF);                   // net -2, clamps negative
        wait_out("sat neg5", 10'h3FF);
        chk("sat sticky", {31'd0, sat}, 32'd1);

        // Coefficient writes while busy and out of range.
        do_reset();
        chk("sat cleared", {31'd0, sat}, 32'd0);
        write_coef(0, 10'h0A0);          // +160
        write_coef(1, 10'h240);          // -64
        chk("idle write ok", {31'd0, coef_err}, 32'd0);
        send(10'h100);                   // 160*256 >> 9 = 80
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 10'h1FF;
        tick();
        coef_we = 1'b0;
        chk("busy coef_err", {31'd0, coef_err}, 32'd1);
        tick();
        chk("coef_err pulse", {31'd0, coef_err}, 32'd0);
        wait_out("busy out", 10'h050);
        send(10'h080);                   // 160*128 - 64*256 = 4096 -> 8
        wait_out("busy golden", 10'h008);
        write_coef(30, 10'h001);
        chk("addr30 coef_err", {31'd0, coef_err}, 32'd1);
        // Same-edge write: 511*256 - 64*128 = 122624 -> 239
        send(10'h100, 1'b1, 0, 10'h1FF);
        wait_out("same-edge write", 10'h0EF);

        // Flow control: in_valid held high, fir_in = edge number.
        // in_ready returns in the out_valid cycle, so accepts land on edges 1, 34, 67, 100.
        do_reset();
        write_coef(0, 10'h1FF);
        np = 0;
        for (int c = 1; c <= 100; c++) begin
            in_valid = 1'b1;
            fir_in   = 10'(c);
            tick();
            if (c == 2 || c == 32) chk($sformatf("flow busy %0d", c), {31'd0, in_ready}, 32'd0);
            if (out_valid) begin
                s = 1 + 33 * np;
                chk($sformatf("flow pulse %0d", np), 32'(c), 32'(s + LAT));
                chk($sformatf("flow value %0d", np), {22'd0, fir_out}, 32'((s * 511) >> 9));
                np++;
            end
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
        fir_in   = '0;
        chk("flow pulses", 32'(np), 32'd3);
        wait_out("flow last", 10'd99);

        // Reset at MAC idx=12: no output, everything cleared.
        send(10'h100);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b0;
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("midrst fir_out", {22'd0, fir_out}, 32'd0);
        chk("midrst sat", {31'd0, sat}, 32'd0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("midrst no out_valid", 32'(pulses), 32'd0);
        send(10'h1FF);
        wait_out("midrst coefs zero", 10'h000);
        write_coef(0, 10'h1FF);
        send(10'h100);                   // 511*256 >> 9 = 255
        wait_out("post reset", 10'h0FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
